// File: rtl/maze_pkg.sv
// maze_pkg: shared codes and state encodings for the maze move sequencer
package maze_pkg;
  typedef enum logic [2:0] {MV_STOP, MV_FWD, MV_LEFT, MV_RIGHT, MV_UTURN} move_t;
  typedef enum logic [1:0] {HD_N, HD_E, HD_S, HD_W} heading_t;
  localparam logic [1:0] MC_NONE  = 2'b00;
  localparam logic [1:0] MC_ADV   = 2'b01;
  localparam logic [1:0] MC_LEFT  = 2'b10;
  localparam logic [1:0] MC_RIGHT = 2'b11;
  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_OOB     = 2'b10;
  localparam logic [1:0] FC_ILLEGAL = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_ROT1, S_ROT2, S_ADV, S_SETTLE, S_SENSE, S_DONE, S_HALT} state_t;
endpackage

// File: rtl/maze_pose_tracker.sv
// maze_pose_tracker: heading and grid position, next-cell lookahead and bounds check
module maze_pose_tracker
  import maze_pkg::*;
#(
  parameter int GRID    = 9,
  parameter int START_X = 4,
  parameter int START_Y = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rot,
  input  logic       rot_left,
  input  logic       adv,
  output logic [1:0] heading,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic       oob
);
  logic [1:0] hd_nx;
  logic [4:0] nx, ny;
  // lookahead uses the post-rotation heading so a rotate finishing this cycle is checked correctly
  always_comb begin
    hd_nx = rot ? heading + (rot_left ? 2'd3 : 2'd1) : heading;
    nx = {1'b0, pos_x} + (hd_nx == HD_E ? 5'd1 : hd_nx == HD_W ? 5'h1f : 5'd0);
    ny = {1'b0, pos_y} + (hd_nx == HD_S ? 5'd1 : hd_nx == HD_N ? 5'h1f : 5'd0);
  end
  assign oob = (nx >= 5'(GRID)) || (ny >= 5'(GRID));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      heading <= HD_N;
      pos_x   <= 4'(START_X);
      pos_y   <= 4'(START_Y);
    end else begin
      heading <= hd_nx;
      if (adv) begin
        pos_x <= nx[3:0];
        pos_y <= ny[3:0];
      end
    end
endmodule

// File: rtl/maze_move_sequencer.sv
// maze_move_sequencer: turns move codes into motor jobs, tracks pose, samples walls, halts on exit/fault
module maze_move_sequencer
  import maze_pkg::*;
#(
  parameter int GRID        = 9,
  parameter int START_X     = 4,
  parameter int START_Y     = 8,
  parameter int EXIT_X      = 4,
  parameter int EXIT_Y      = 0,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_move,
  output logic       cmd_ready,
  output logic       mot_start,
  output logic [1:0] mot_cmd,
  input  logic       mot_done,
  input  logic       wall_l,
  input  logic       wall_m,
  input  logic       wall_r,
  output logic       sense_valid,
  output logic [2:0] walls_out,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic [1:0] heading,
  output logic       exit_reached,
  output logic       fault,
  output logic [1:0] fault_code
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  state_t state;
  logic [TW-1:0] timer;
  logic [SW-1:0] settle;
  logic left, uturn, oob, rot, adv;
  assign rot = (state == S_ROT1 || state == S_ROT2) && mot_done;
  assign adv = (state == S_ADV) && mot_done;
  maze_pose_tracker #(.GRID(GRID), .START_X(START_X), .START_Y(START_Y)) u_pose (
    .clk(clk), .rst_n(rst_n), .rot(rot), .rot_left(left), .adv(adv),
    .heading(heading), .pos_x(pos_x), .pos_y(pos_y), .oob(oob)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= S_IDLE;
      cmd_ready    <= 1'b1;
      mot_start    <= 1'b0;
      mot_cmd      <= MC_NONE;
      sense_valid  <= 1'b0;
      walls_out    <= 3'b000;
      exit_reached <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= FC_NONE;
      timer        <= '0;
      settle       <= '0;
      left         <= 1'b0;
      uturn        <= 1'b0;
    end else begin
      mot_start   <= 1'b0;
      sense_valid <= 1'b0;
      case (state)
        S_IDLE:
          if (cmd_valid) begin
            timer <= '0;
            if (cmd_move == MV_FWD) begin
              cmd_ready <= 1'b0;
              if (oob) begin
                state      <= S_HALT;
                fault      <= 1'b1;
                fault_code <= FC_OOB;
              end else begin
                state     <= S_ADV;
                mot_start <= 1'b1;
                mot_cmd   <= MC_ADV;
              end
            end else if (cmd_move inside {MV_LEFT, MV_RIGHT, MV_UTURN}) begin
              cmd_ready <= 1'b0;
              state     <= S_ROT1;
              mot_start <= 1'b1;
              mot_cmd   <= cmd_move == MV_LEFT ? MC_LEFT : MC_RIGHT;
              left      <= cmd_move == MV_LEFT;
              uturn     <= cmd_move == MV_UTURN;
            end else if (cmd_move != MV_STOP) begin
              cmd_ready  <= 1'b0;
              state      <= S_HALT;
              fault      <= 1'b1;
              fault_code <= FC_ILLEGAL;
            end
          end
        S_ROT1, S_ROT2, S_ADV:
          // a done arriving on the expiry cycle is checked first, so it beats the timeout
          if (mot_done) begin
            timer <= '0;
            if (state == S_ROT1 && uturn) begin
              state     <= S_ROT2;
              mot_start <= 1'b1;
              mot_cmd   <= MC_RIGHT;
              left      <= 1'b0;
            end else if (state == S_ADV) begin
              state   <= S_SETTLE;
              settle  <= '0;
              mot_cmd <= MC_NONE;
            end else if (oob) begin
              state      <= S_HALT;
              fault      <= 1'b1;
              fault_code <= FC_OOB;
              mot_cmd    <= MC_NONE;
            end else begin
              state     <= S_ADV;
              mot_start <= 1'b1;
              mot_cmd   <= MC_ADV;
            end
          end else if (timer == TW'(TIMEOUT_CYC)) begin
            state      <= S_HALT;
            fault      <= 1'b1;
            fault_code <= FC_TIMEOUT;
            mot_cmd    <= MC_NONE;
          end else
            timer <= timer + 1'b1;
        S_SETTLE:
          if (settle == SW'(SETTLE_CYC - 1)) begin
            state       <= S_SENSE;
            sense_valid <= 1'b1;
            walls_out   <= {wall_l, wall_m, wall_r};
          end else
            settle <= settle + 1'b1;
        S_SENSE:
          if (pos_x == 4'(EXIT_X) && pos_y == 4'(EXIT_Y)) begin
            state        <= S_DONE;
            exit_reached <= 1'b1;
          end else begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_maze_move_sequencer.sv
// tb_maze_move_sequencer: table-driven move vectors plus hand-written fault/exit/reset sequences
module tb_maze_move_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, mot_done = 1'b0;
  logic wall_l = 1'b0, wall_m = 1'b0, wall_r = 1'b0;
  logic [2:0] cmd_move = 3'd0;
  logic cmd_ready, mot_start, sense_valid, exit_reached, fault;
  logic [1:0] mot_cmd, heading, fault_code;
  logic [2:0] walls_out;
  logic [3:0] pos_x, pos_y;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  maze_move_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_move(cmd_move),
    .cmd_ready(cmd_ready), .mot_start(mot_start), .mot_cmd(mot_cmd), .mot_done(mot_done),
    .wall_l(wall_l), .wall_m(wall_m), .wall_r(wall_r), .sense_valid(sense_valid),
    .walls_out(walls_out), .pos_x(pos_x), .pos_y(pos_y), .heading(heading),
    .exit_reached(exit_reached), .fault(fault), .fault_code(fault_code)
  );

  typedef struct {
    logic [2:0] mv;
    int nj;
    logic [5:0] cmds;
    logic [2:0] w;
    int dly;
    int ex, ey, eh;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; mot_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_pose(input string nm, input int ex, input int ey, input int eh);
    chk({nm, "_x"}, pos_x, ex);
    chk({nm, "_y"}, pos_y, ey);
    chk({nm, "_hd"}, heading, eh);
  endtask

  // issue one move and serve its motor jobs; ends one cycle after sense_valid
  task automatic do_move(input logic [2:0] mv, input int nj, input logic [5:0] cmds,
                         input logic [2:0] w, input int dly, input int exp_rdy);
    logic [1:0] c;
    {wall_l, wall_m, wall_r} = w;
    chk("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_move = mv;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int j = 0; j < nj; j++) begin
      c = cmds[5-2*j -: 2];
      chk("mot_start", mot_start, 1);
      chk("mot_cmd", mot_cmd, c);
      @(negedge clk);
      chk("start_pulse", mot_start, 0);
      repeat (dly - 1) @(negedge clk);
      chk("mot_cmd_held", mot_cmd, c);
      mot_done = 1'b1;
      @(negedge clk);
      mot_done = 1'b0;
    end
    if (nj == 0) chk("stop_no_start", mot_start, 0);
    else begin
      chk("mot_cmd_clear", mot_cmd, 0);
      repeat (4) begin
        chk("sense_early", sense_valid, 0);
        @(negedge clk);
      end
      chk("sense_valid", sense_valid, 1);
      chk("walls_out", walls_out, w);
      @(negedge clk);
      chk("sense_pulse", sense_valid, 0);
    end
    chk("ready_after", cmd_ready, exp_rdy);
  endtask

  initial begin
    vt[0] = '{3'd1, 1, 6'b010000, 3'b101, 10, 4, 7, 0};
    vt[1] = '{3'd2, 2, 6'b100100, 3'b010, 3, 3, 7, 3};
    vt[2] = '{3'd3, 2, 6'b110100, 3'b011, 1, 3, 6, 0};
    vt[3] = '{3'd4, 3, 6'b111101, 3'b100, 5, 3, 7, 2};
    vt[4] = '{3'd0, 0, 6'b000000, 3'b000, 1, 3, 7, 2};
    vt[5] = '{3'd3, 2, 6'b110100, 3'b001, 2, 2, 7, 3};
    vt[6] = '{3'd3, 2, 6'b110100, 3'b110, 4, 2, 6, 0};

    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_start", mot_start, 0);
    chk("rst_cmd", mot_cmd, 0);
    chk("rst_fault", fault, 0);
    chk("rst_exit", exit_reached, 0);
    chk_pose("rst", 4, 8, 0);
    do_reset();

    foreach (vt[i]) begin
      do_move(vt[i].mv, vt[i].nj, vt[i].cmds, vt[i].w, vt[i].dly, 1);
      chk_pose("vec", vt[i].ex, vt[i].ey, vt[i].eh);
    end

    // walk north to the top row at x=2, then one more step must fault out-of-bounds
    repeat (6) do_move(3'd1, 1, 6'b010000, 3'b000, 2, 1);
    chk_pose("top_row", 2, 0, 0);
    cmd_valid = 1'b1; cmd_move = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("oob_start", mot_start, 0);
    chk("oob_fault", fault, 1);
    chk("oob_code", fault_code, 2);
    chk("oob_ready", cmd_ready, 0);
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    chk("halt_start", mot_start, 0);
    chk("halt_ready", cmd_ready, 0);
    chk_pose("halt", 2, 0, 0);

    // motor timeout
    do_reset();
    cmd_valid = 1'b1; cmd_move = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("to_start", mot_start, 1);
    repeat (1000) @(negedge clk);
    chk("to_not_yet", fault, 0);
    @(negedge clk);
    chk("to_fault", fault, 1);
    chk("to_code", fault_code, 1);
    chk("to_cmd", mot_cmd, 0);
    chk("to_ready", cmd_ready, 0);
    mot_done = 1'b1;
    @(negedge clk);
    mot_done = 1'b0;
    chk("to_pose_y", pos_y, 8);

    // done on the expiry cycle beats the timeout
    do_reset();
    cmd_valid = 1'b1; cmd_move = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (1000) @(negedge clk);
    mot_done = 1'b1;
    @(negedge clk);
    mot_done = 1'b0;
    chk("race_fault", fault, 0);
    chk("race_y", pos_y, 7);
    repeat (4) @(negedge clk);
    chk("race_sense", sense_valid, 1);

    // illegal move code
    do_reset();
    cmd_valid = 1'b1; cmd_move = 3'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ill_fault", fault, 1);
    chk("ill_code", fault_code, 3);
    chk("ill_ready", cmd_ready, 0);
    chk("ill_start", mot_start, 0);

    // straight run to the exit
    do_reset();
    repeat (7) do_move(3'd1, 1, 6'b010000, 3'b010, 1, 1);
    do_move(3'd1, 1, 6'b010000, 3'b111, 1, 0);
    chk_pose("exit", 4, 0, 0);
    chk("exit_flag", exit_reached, 1);
    cmd_valid = 1'b1; cmd_move = 3'd2;
    repeat (4) @(negedge clk);
    cmd_valid = 1'b0;
    chk("exit_ready", cmd_ready, 0);
    chk("exit_start", mot_start, 0);
    chk("exit_sticky", exit_reached, 1);
    chk("exit_nofault", fault, 0);

    // reset in the middle of an advance
    do_reset();
    do_move(3'd1, 1, 6'b010000, 3'b000, 2, 1);
    cmd_valid = 1'b1; cmd_move = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_start", mot_start, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_start_clr", mot_start, 0);
    chk("mid_cmd_clr", mot_cmd, 0);
    chk("mid_ready", cmd_ready, 1);
    chk_pose("mid", 4, 8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_pose("mid_after", 4, 8, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
